// File: rtl/nn_cfg_pkg.sv
// Shared definitions for the weight-configuration broadcast bus:
// loader states, header field positions and bus word width.
package nn_cfg_pkg;

    localparam int unsigned CFG_WORD_BITS = 32;

    localparam int unsigned LAYER_MSB  = 31;
    localparam int unsigned LAYER_LSB  = 16;
    localparam int unsigned NEURON_MSB = 15;
    localparam int unsigned NEURON_LSB = 0;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_CNT   = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/weight_config_loader_if.sv
// Host stream input plus the neuron-facing broadcast outputs of the loader.
// master = loader side, slave = host/observer side.
interface weight_config_loader_if;
    import nn_cfg_pkg::*;

    logic                     s_valid;
    logic [CFG_WORD_BITS-1:0] s_data;
    logic                     s_last;
    logic                     s_ready;

    logic                     weight_valid;
    logic [CFG_WORD_BITS-1:0] weight_value;
    logic [CFG_WORD_BITS-1:0] config_layer_no;
    logic [CFG_WORD_BITS-1:0] config_neuron_no;
    logic                     busy;
    logic                     done;
    logic                     error;

    modport master (
        input  s_valid, s_data, s_last,
        output s_ready, weight_valid, weight_value,
               config_layer_no, config_neuron_no, busy, done, error
    );

    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready, weight_valid, weight_value,
               config_layer_no, config_neuron_no, busy, done, error
    );

endinterface

// File: rtl/weight_config_loader.sv
// Unpacks framed weight packets from the host stream and replays the payload
// as single-cycle weight beats tagged with layer/neuron on the broadcast bus.
module weight_config_loader
    import nn_cfg_pkg::*;
#(
    parameter int unsigned data_bits   = 16,
    parameter int unsigned max_weights = 784
) (
    input  logic                   clk,
    input  logic                   reset,
    weight_config_loader_if.master bus
);

    localparam int unsigned count_bits = $clog2(max_weights + 1);

    state_t                   state, state_d;
    logic [count_bits-1:0]    remaining, remaining_d;
    logic                     weight_valid_d;
    logic [CFG_WORD_BITS-1:0] weight_value_d;
    logic [CFG_WORD_BITS-1:0] layer_d;
    logic [CFG_WORD_BITS-1:0] neuron_d;
    logic                     done_d;
    logic                     error_d;
    logic                     accept_c;
    logic                     bad_count_c;

    assign accept_c    = bus.s_valid & bus.s_ready;
    assign bad_count_c = (bus.s_data == '0) ||
                         (bus.s_data > CFG_WORD_BITS'(max_weights));

    // Next-state and next-output decode; everything is registered below.
    always_comb begin
        state_d        = state;
        remaining_d    = remaining;
        weight_valid_d = 1'b0;
        weight_value_d = bus.weight_value;
        layer_d        = bus.config_layer_no;
        neuron_d       = bus.config_neuron_no;
        done_d         = 1'b0;
        error_d        = 1'b0;

        if (accept_c) begin
            case (state)
                S_HDR: begin
                    layer_d  = CFG_WORD_BITS'(bus.s_data[LAYER_MSB:LAYER_LSB]);
                    neuron_d = CFG_WORD_BITS'(bus.s_data[NEURON_MSB:NEURON_LSB]);
                    if (bus.s_last) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = S_CNT;
                    end
                end
                S_CNT: begin
                    if (bad_count_c) begin
                        error_d = 1'b1;
                        state_d = bus.s_last ? S_HDR : S_DRAIN;
                    end else begin
                        remaining_d = count_bits'(bus.s_data);
                        if (bus.s_last) begin
                            error_d = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    weight_valid_d = 1'b1;
                    weight_value_d = CFG_WORD_BITS'($signed(bus.s_data[data_bits-1:0]));
                    remaining_d    = remaining - count_bits'(1);
                    if (remaining == count_bits'(1)) begin
                        if (bus.s_last) begin
                            done_d  = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            error_d = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (bus.s_last) begin
                        // Short packet: keep the weight, flag the truncation.
                        error_d = 1'b1;
                        state_d = S_HDR;
                    end
                end
                S_DRAIN: begin
                    if (bus.s_last) begin
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= S_HDR;
            remaining            <= '0;
            bus.s_ready          <= 1'b0;
            bus.weight_valid     <= 1'b0;
            bus.weight_value     <= '0;
            bus.config_layer_no  <= '0;
            bus.config_neuron_no <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.error            <= 1'b0;
        end else begin
            state                <= state_d;
            remaining            <= remaining_d;
            bus.s_ready          <= 1'b1;
            bus.weight_valid     <= weight_valid_d;
            bus.weight_value     <= weight_value_d;
            bus.config_layer_no  <= layer_d;
            bus.config_neuron_no <= neuron_d;
            bus.busy             <= (state_d != S_HDR);
            bus.done             <= done_d;
            bus.error            <= error_d;
        end
    end

endmodule

// File: tb/tb_weight_config_loader.sv
// Self-checking bench for weight_config_loader: directed packets with literal
// expectations plus randomized packet streams against a packet-level model.
module tb_weight_config_loader;
    import nn_cfg_pkg::*;

    localparam int MAXW = 784;

    logic clk = 1'b0;
    logic reset;

    weight_config_loader_if bus ();

    weight_config_loader #(.data_bits(16), .max_weights(MAXW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: position in packet, declared count, weights seen.
    logic        exp_ready, exp_wv, exp_busy, exp_done, exp_err;
    logic [31:0] exp_val, exp_layer, exp_neuron;
    int          pos;
    bit          drain;
    int          n_decl, got;

    task automatic model_step();
        logic [31:0] d;
        bit          last;
        if (reset) begin
            exp_ready = 0; exp_wv = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_val = 0; exp_layer = 0; exp_neuron = 0;
            pos = 0; drain = 0; n_decl = 0; got = 0;
            return;
        end
        d = bus.s_data;
        last = bus.s_last;
        exp_wv = 0; exp_done = 0; exp_err = 0;
        if (bus.s_valid && exp_ready) begin
            if (drain) begin
                if (last) drain = 0;
            end else if (pos == 0) begin
                exp_layer  = {16'h0, d[31:16]};
                exp_neuron = {16'h0, d[15:0]};
                if (last) exp_err = 1; else pos = 1;
            end else if (pos == 1) begin
                if (d == 0 || d > 32'(MAXW)) begin
                    exp_err = 1;
                    pos = 0;
                    if (!last) drain = 1;
                end else if (last) begin
                    exp_err = 1;
                    pos = 0;
                end else begin
                    n_decl = int'(d);
                    got = 0;
                    pos = 2;
                end
            end else begin
                got++;
                exp_wv = 1;
                exp_val = {{16{d[15]}}, d[15:0]};
                if (got == n_decl) begin
                    pos = 0;
                    if (last) exp_done = 1;
                    else begin exp_err = 1; drain = 1; end
                end else if (last) begin
                    exp_err = 1;
                    pos = 0;
                end
            end
        end
        exp_ready = 1;
        exp_busy = drain || (pos != 0);
    endtask

    always @(posedge clk or posedge reset) model_step();

    // Observed-beat log for the directed literal checks.
    logic [31:0] beats[$];
    logic [31:0] beat_layer[$];
    logic [31:0] beat_neuron[$];
    int done_cnt, err_cnt;

    task automatic compare_step();
        chk("s_ready", 32'(bus.s_ready), 32'(exp_ready));
        chk("weight_valid", 32'(bus.weight_valid), 32'(exp_wv));
        if (exp_wv) begin
            chk("weight_value", bus.weight_value, exp_val);
            chk("layer_on_beat", bus.config_layer_no, exp_layer);
            chk("neuron_on_beat", bus.config_neuron_no, exp_neuron);
        end
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("error", 32'(bus.error), 32'(exp_err));
        chk("done_error_exclusive", 32'(bus.done & bus.error), 32'h0);
        if (bus.weight_valid) begin
            beats.push_back(bus.weight_value);
            beat_layer.push_back(bus.config_layer_no);
            beat_neuron.push_back(bus.config_neuron_no);
        end
        if (bus.done)  done_cnt++;
        if (bus.error) err_cnt++;
    endtask

    always @(negedge clk) if (!reset) compare_step();

    task automatic clear_log();
        beats.delete(); beat_layer.delete(); beat_neuron.delete();
        done_cnt = 0; err_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [31:0] d, input bit last, input int gap);
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = $urandom;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_counts(input string name, input int nb, input int nd, input int ne);
        chk({name, "_beats"}, 32'(beats.size()), 32'(nb));
        chk({name, "_done"},  32'(done_cnt), 32'(nd));
        chk({name, "_error"}, 32'(err_cnt), 32'(ne));
    endtask

    task automatic nominal(input string name, input int gap);
        clear_log();
        put(32'h0001_0003, 0, gap);
        put(32'd3, 0, gap);
        put(32'h0000_0005, 0, gap);
        put(32'h0000_FFFE, 0, gap);
        put(32'h0000_7FFF, 1, gap);
        idle(3);
        chk_counts(name, 3, 1, 0);
        if (beats.size() == 3) begin
            chk({name, "_w0"}, beats[0], 32'h0000_0005);
            chk({name, "_w1"}, beats[1], 32'hFFFF_FFFE);
            chk({name, "_w2"}, beats[2], 32'h0000_7FFF);
            chk({name, "_layer"}, beat_layer[2], 32'd1);
            chk({name, "_neuron"}, beat_neuron[0], 32'd3);
        end
        chk({name, "_busy_after"}, 32'(bus.busy), 32'h0);
    endtask

    task automatic bad_count(input string name, input logic [31:0] n);
        clear_log();
        put(32'h0004_0005, 0, 0);
        put(n, 0, 0);
        for (int i = 0; i < 4; i++) put($urandom, i == 3, 0);
        idle(2);
        chk_counts(name, 0, 0, 1);
        chk({name, "_busy_after"}, 32'(bus.busy), 32'h0);
    endtask

    function automatic int rgap();
        return ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0;
        reset = 1'b1;
        clear_log();
        #23;
        chk("reset_weight_valid", 32'(bus.weight_valid), 32'h0);
        chk("reset_layer", bus.config_layer_no, 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_ready", 32'(bus.s_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        nominal("nominal", 0);
        nominal("gapped", 2);

        bad_count("count0", 32'd0);
        bad_count("count785", 32'h0000_0311);

        // Short packet: count 4, s_last on second weight.
        clear_log();
        put(32'h0002_0001, 0, 0); put(32'd4, 0, 0);
        put(32'h0011, 0, 0); put(32'h0022, 1, 0);
        idle(2);
        chk_counts("short", 2, 0, 1);

        // Long packet: count 2, no s_last, then drain to s_last.
        clear_log();
        put(32'h0002_0002, 0, 0); put(32'd2, 0, 0);
        put(32'h0033, 0, 0); put(32'h0044, 0, 0);
        put(32'h0055, 0, 0); put(32'h0066, 1, 0);
        idle(2);
        chk_counts("long", 2, 0, 1);
        chk("long_busy_after", 32'(bus.busy), 32'h0);

        // Back-to-back packets with a tag change.
        clear_log();
        put(32'h0000_0007, 0, 0); put(32'd1, 0, 0); put(32'h1234, 1, 0);
        put(32'h0002_0000, 0, 0); put(32'd2, 0, 0);
        put(32'h8000, 0, 0); put(32'h0001, 1, 0);
        idle(2);
        chk_counts("b2b", 3, 2, 0);
        if (beats.size() == 3) begin
            chk("b2b_w0", beats[0], 32'h0000_1234);
            chk("b2b_l0", beat_layer[0], 32'd0);
            chk("b2b_n0", beat_neuron[0], 32'd7);
            chk("b2b_w1", beats[1], 32'hFFFF_8000);
            chk("b2b_l1", beat_layer[1], 32'd2);
            chk("b2b_n1", beat_neuron[1], 32'd0);
        end

        // Asynchronous reset mid-payload.
        clear_log();
        put(32'h0003_0004, 0, 0); put(32'd784, 0, 0);
        for (int i = 1; i <= 10; i++) put(32'(i), 0, 0);
        chk("rst_pre_wv", 32'(bus.weight_valid), 32'h1);
        chk("rst_pre_busy", 32'(bus.busy), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst_wv", 32'(bus.weight_valid), 32'h0);
        chk("rst_layer", bus.config_layer_no, 32'h0);
        chk("rst_neuron", bus.config_neuron_no, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        clear_log();
        put(32'h0009_000A, 0, 0); put(32'd1, 0, 0); put(32'h0042, 1, 0);
        idle(2);
        chk_counts("post_rst", 1, 1, 0);
        if (beats.size() == 1) begin
            chk("post_rst_w", beats[0], 32'h0000_0042);
            chk("post_rst_layer", beat_layer[0], 32'd9);
            chk("post_rst_neuron", beat_neuron[0], 32'd10);
        end

        // Maximum legal packet.
        clear_log();
        put($urandom, 0, 0); put(32'(MAXW), 0, 0);
        for (int i = 0; i < MAXW; i++) put($urandom, i == MAXW - 1, 0);
        idle(2);
        chk_counts("max784", MAXW, 1, 0);

        // Randomized packet stream; per-cycle model comparison does the checking.
        for (int p = 0; p < 300; p++) begin
            int k, n, m;
            logic [31:0] hdr;
            hdr = $urandom;
            n = $urandom_range(1, 12);
            k = $urandom % 10;
            case (k)
                0: put(hdr, 1, rgap());
                1: begin
                    put(hdr, 0, rgap());
                    put(($urandom % 2) ? 32'h0 : 32'($urandom_range(785, 5000)), 0, rgap());
                    m = $urandom_range(1, 4);
                    for (int i = 0; i < m; i++) put($urandom, i == m - 1, rgap());
                end
                2: begin put(hdr, 0, rgap()); put(32'(n), 1, rgap()); end
                3: begin
                    if (n < 2) n = 2;
                    m = $urandom_range(1, n - 1);
                    put(hdr, 0, rgap()); put(32'(n), 0, rgap());
                    for (int i = 0; i < m; i++) put($urandom, i == m - 1, rgap());
                end
                4: begin
                    put(hdr, 0, rgap()); put(32'(n), 0, rgap());
                    for (int i = 0; i < n; i++) put($urandom, 0, rgap());
                    m = $urandom_range(1, 3);
                    for (int i = 0; i < m; i++) put($urandom, i == m - 1, rgap());
                end
                5: begin put(hdr, 0, rgap()); put(32'h0, 1, rgap()); end
                default: begin
                    put(hdr, 0, rgap()); put(32'(n), 0, rgap());
                    for (int i = 0; i < n; i++) put($urandom, i == n - 1, rgap());
                end
            endcase
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
